// File: rtl/vin_line_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : vin_line_buf_if
//  Purpose  : Bundles the camera-side pixel stream and the DDR-writer-side
//             read/notify signals of vin_line_buf.
//  Signals  : cam_vs / cam_de / cam_pix[15:0]   camera stream (to buffer)
//             vinra[5:0]                        read word address (to buffer)
//             vinrdo[31:0]                      registered read data
//             vinwi / vinwfi                    bank-ready / frame-start pulses
//             vin_ovf / vin_short               sticky error flags
//  Modports : master = camera + DDR writer side, slave = line buffer
//  Revision : 1.0  initial release
// ============================================================================
interface vin_line_buf_if;
    logic        cam_vs;
    logic        cam_de;
    logic [15:0] cam_pix;
    logic [5:0]  vinra;
    logic [31:0] vinrdo;
    logic        vinwi;
    logic        vinwfi;
    logic        vin_ovf;
    logic        vin_short;

    modport master (
        output cam_vs, cam_de, cam_pix, vinra,
        input  vinrdo, vinwi, vinwfi, vin_ovf, vin_short
    );

    modport slave (
        input  cam_vs, cam_de, cam_pix, vinra,
        output vinrdo, vinwi, vinwfi, vin_ovf, vin_short
    );
endinterface
`default_nettype wire

// File: rtl/vin_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : vin_line_buf
//  Purpose  : Capture-side ping-pong line buffer. Packs RGB565 pixel pairs
//             into 32-bit words, fills two 64-word banks alternately,
//             announces full banks (vinwi) and frame starts (vinwfi), and
//             serves random registered reads of the last completed bank.
//  Ports    : clkddr  system/DDR clock (single domain)
//             rstn    asynchronous active-low reset
//             bus     vin_line_buf_if.slave (camera in, read port, flags out)
//  Params   : FRM_WORDS  words per frame, multiple of 64
//             RD_WIN     clocks a bank stays read-locked after its vinwi
//  Revision : 1.0  initial release
// ============================================================================
module vin_line_buf #(
    parameter int FRM_WORDS = 192000,
    parameter int RD_WIN    = 96
) (
    input  wire logic          clkddr,
    input  wire logic          rstn,
    vin_line_buf_if.slave      bus
);

    localparam int                c_FCW      = $clog2(FRM_WORDS + 1);
    localparam int                c_TW       = $clog2(RD_WIN + 1);
    localparam logic [c_FCW-1:0]  c_FRM_LAST = c_FCW'(FRM_WORDS - 1);
    localparam logic [c_TW-1:0]   c_RD_WIN   = c_TW'(RD_WIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_half;
    logic [15:0]        r_lo;
    logic               r_wr_en;
    logic [31:0]        r_wr_data;
    logic [5:0]         r_wcnt;
    logic [c_FCW-1:0]   r_fcnt;
    logic               r_wbank;
    logic               r_rbank;
    logic [c_TW-1:0]    r_tmr [2];
    logic               r_vinwi;
    logic               r_wi_pend;
    logic               r_vinwfi;
    logic               r_ovf;
    logic               r_short;
    logic [31:0]        r_rdo;
    logic [31:0]        r_mem [128];

    logic               w_wr;
    logic               w_wrap;
    logic               w_locked;
    logic               w_done;
    logic               w_frame_end;
    logic               w_acc;
    logic               w_wi_req;

    // A frame-start pulse discards the word still waiting to be written.
    assign w_wr        = r_wr_en && !bus.cam_vs;
    assign w_wrap      = w_wr && (r_wcnt == 6'd63);
    assign w_locked    = (r_tmr[~r_wbank] != '0);
    assign w_done      = w_wrap && !w_locked;
    assign w_frame_end = w_done && (r_fcnt == c_FRM_LAST);
    // Pixels are taken in RUN, or as the first pixel of a frame on cam_vs.
    // The clock that closes the frame already belongs to HOLD.
    assign w_acc       = bus.cam_de &&
                         (bus.cam_vs || (r_state == ST_RUN && !w_frame_end));
    assign w_wi_req    = w_done || r_wi_pend;

    always_ff @(posedge clkddr or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.cam_vs) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.cam_vs)       w_state_nxt = ST_RUN;
                else if (w_frame_end) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: if (bus.cam_vs) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkddr or negedge rstn) begin
        if (!rstn) begin
            r_half    <= 1'b0;
            r_lo      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wcnt    <= '0;
            r_fcnt    <= '0;
            r_wbank   <= 1'b0;
            r_rbank   <= 1'b0;
            r_ovf     <= 1'b0;
            r_short   <= 1'b0;
        end else if (bus.cam_vs) begin
            if (r_state == ST_RUN && r_fcnt != c_FCW'(FRM_WORDS))
                r_short <= 1'b1;
            r_wr_en <= 1'b0;
            r_wcnt  <= '0;
            r_fcnt  <= '0;
            r_half  <= bus.cam_de;
            if (bus.cam_de) r_lo <= bus.cam_pix;
        end else begin
            r_wr_en <= 1'b0;
            if (w_acc) begin
                if (r_half) begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= {bus.cam_pix, r_lo};
                    r_half    <= 1'b0;
                end else begin
                    r_lo   <= bus.cam_pix;
                    r_half <= 1'b1;
                end
            end
            if (w_wr) begin
                r_wcnt <= r_wcnt + 6'd1;
                // A dropped chunk is taken back out of the frame count so
                // the frame still ends after FRM_WORDS stored words.
                if (w_wrap && w_locked) begin
                    r_fcnt <= r_fcnt - c_FCW'(63);
                    r_ovf  <= 1'b1;
                end else begin
                    r_fcnt <= r_fcnt + c_FCW'(1);
                end
            end
            if (w_done) begin
                r_rbank <= r_wbank;
                r_wbank <= ~r_wbank;
            end
        end
    end

    always_ff @(posedge clkddr or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) r_tmr[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_done && (r_wbank == 1'(b)))
                    r_tmr[b] <= c_RD_WIN;
                else if (r_tmr[b] != '0)
                    r_tmr[b] <= r_tmr[b] - c_TW'(1);
            end
        end
    end

    // vinwfi has priority; a colliding bank-ready pulse slips one clock.
    always_ff @(posedge clkddr or negedge rstn) begin
        if (!rstn) begin
            r_vinwfi  <= 1'b0;
            r_vinwi   <= 1'b0;
            r_wi_pend <= 1'b0;
        end else begin
            r_vinwfi <= bus.cam_vs;
            if (bus.cam_vs) begin
                r_vinwi   <= 1'b0;
                r_wi_pend <= w_wi_req;
            end else begin
                r_vinwi   <= w_wi_req;
                r_wi_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clkddr) begin
        if (w_wr) r_mem[{r_wbank, r_wcnt}] <= r_wr_data;
    end

    always_ff @(posedge clkddr or negedge rstn) begin
        if (!rstn) r_rdo <= '0;
        else       r_rdo <= r_mem[{r_rbank, bus.vinra}];
    end

    assign bus.vinrdo    = r_rdo;
    assign bus.vinwi     = r_vinwi;
    assign bus.vinwfi    = r_vinwfi;
    assign bus.vin_ovf   = r_ovf;
    assign bus.vin_short = r_short;

endmodule
`default_nettype wire
